// File: rtl/rom_dl_sdram_packer.sv
// HPS ioctl ROM download -> SDRAM write bridge.
// Packs bytes into 16-bit words, queues them in a small FIFO and drains them over req/ack.
module rom_dl_sdram_packer #(
  parameter logic [15:0] ROM_INDEX  = 16'd0,
  parameter int          WADDR_W    = 22,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic               i_EMU_MCLK,
  input  logic               i_EMU_INITRST_n,
  input  logic               ioctl_download,
  input  logic [15:0]        ioctl_index,
  input  logic [26:0]        ioctl_addr,
  input  logic [7:0]         ioctl_data,
  input  logic               ioctl_wr,
  output logic               ioctl_wait,
  output logic               o_SDRAM_WR_REQ,
  output logic [WADDR_W-1:0] o_SDRAM_WR_ADDR,
  output logic [15:0]        o_SDRAM_WR_DATA,
  output logic [1:0]         o_SDRAM_WR_BE,
  input  logic               i_SDRAM_WR_ACK,
  output logic               o_DL_BUSY,
  output logic               o_DL_DONE
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] WAIT_CNT = CW'(FIFO_DEPTH - 1);

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, DRAIN, DONE} state_t;

  state_t state_reg;
  logic dl_prev_reg, rearm_reg, busy_reg, done_reg, req_reg;
  logic pend_valid_reg, pend_valid_next;
  logic [7:0] pend_data_reg, pend_data_next;
  logic [WADDR_W-1:0] pend_addr_reg, pend_addr_next;

  logic [WADDR_W-1:0] mem_addr [FIFO_DEPTH];
  logic [15:0]        mem_data [FIFO_DEPTH];
  logic [1:0]         mem_be   [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;

  logic index_ok, accept, dl_rise, push_req, push, pop, space;
  logic [WADDR_W-1:0] waddr, push_addr;
  logic [15:0] push_data;
  logic [1:0] push_be;
  logic unused_addr_bits;

  assign index_ok = (ioctl_index == ROM_INDEX);
  assign accept   = ioctl_wr & ioctl_download & index_ok;
  assign dl_rise  = ioctl_download & ~dl_prev_reg & index_ok;
  assign waddr    = ioctl_addr[WADDR_W:1];
  assign unused_addr_bits = ^ioctl_addr[26:WADDR_W+1];

  assign pop   = i_SDRAM_WR_ACK & req_reg;
  assign space = (count_reg < FULL_CNT) | pop;
  assign push  = push_req & space;

  // Byte packing: at most one FIFO entry per cycle; a displaced even byte rides in the pending register.
  always_comb begin
    push_req        = 1'b0;
    push_addr       = pend_addr_reg;
    push_data       = {8'h00, pend_data_reg};
    push_be         = 2'b01;
    pend_valid_next = pend_valid_reg;
    pend_data_next  = pend_data_reg;
    pend_addr_next  = pend_addr_reg;
    if (accept) begin
      if (ioctl_addr[0]) begin
        push_req  = 1'b1;
        push_addr = waddr;
        if (pend_valid_reg && pend_addr_reg == waddr) begin
          push_data       = {ioctl_data, pend_data_reg};
          push_be         = 2'b11;
          pend_valid_next = 1'b0;
        end else begin
          push_data = {ioctl_data, 8'h00};
          push_be   = 2'b10;
        end
      end else begin
        push_req        = pend_valid_reg;
        pend_valid_next = 1'b1;
        pend_data_next  = ioctl_data;
        pend_addr_next  = waddr;
      end
    end else if (state_reg == FLUSH && pend_valid_reg) begin
      push_req        = 1'b1;
      pend_valid_next = ~space;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge i_EMU_MCLK) begin
    if (push) begin
      mem_addr[wr_ptr_reg] <= push_addr;
      mem_data[wr_ptr_reg] <= push_data;
      mem_be[wr_ptr_reg]   <= push_be;
    end
  end

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
    if (!i_EMU_INITRST_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      req_reg        <= 1'b0;
      pend_valid_reg <= 1'b0;
      pend_data_reg  <= '0;
      pend_addr_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg      <= count_next;
      req_reg        <= (count_next != '0);
      pend_valid_reg <= pend_valid_next;
      pend_data_reg  <= pend_data_next;
      pend_addr_reg  <= pend_addr_next;
    end
  end

  // A rising download seen while still draining is remembered and replayed from IDLE.
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
    if (!i_EMU_INITRST_n) begin
      state_reg   <= IDLE;
      dl_prev_reg <= 1'b0;
      rearm_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      dl_prev_reg <= ioctl_download;
      done_reg    <= 1'b0;
      case (state_reg)
        IDLE: begin
          rearm_reg <= 1'b0;
          if (dl_rise || (rearm_reg && ioctl_download)) begin
            state_reg <= LOAD;
            busy_reg  <= 1'b1;
          end
        end
        LOAD: begin
          if (!ioctl_download) state_reg <= FLUSH;
        end
        FLUSH: begin
          if (dl_rise) rearm_reg <= 1'b1;
          if (!pend_valid_next) state_reg <= DRAIN;
        end
        DRAIN: begin
          if (dl_rise) rearm_reg <= 1'b1;
          if (count_reg == '0 && !push) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end
        end
        DONE: begin
          if (dl_rise) rearm_reg <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    case (state_reg)
      IDLE:    ioctl_wait = 1'b0;
      LOAD:    ioctl_wait = (count_reg >= WAIT_CNT);
      default: ioctl_wait = ioctl_download;
    endcase
  end

  assign o_SDRAM_WR_REQ  = req_reg;
  assign o_SDRAM_WR_ADDR = req_reg ? mem_addr[rd_ptr_reg] : '0;
  assign o_SDRAM_WR_DATA = req_reg ? mem_data[rd_ptr_reg] : '0;
  assign o_SDRAM_WR_BE   = req_reg ? mem_be[rd_ptr_reg]   : '0;
  assign o_DL_BUSY       = busy_reg;
  assign o_DL_DONE       = done_reg;

endmodule

// File: tb/tb_rom_dl_sdram_packer.sv
// Directed bench for rom_dl_sdram_packer: stimulus pushes expected SDRAM writes into a
// scoreboard queue, a separate responder/monitor acks requests and compares them.
module tb_rom_dl_sdram_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        download = 1'b0;
  logic [15:0] index = 16'd0;
  logic [26:0] addr = '0;
  logic [7:0]  data = '0;
  logic        wr = 1'b0;
  logic        ack = 1'b0;
  logic        wait_o, req, busy, done;
  logic [21:0] wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  bit ack_en = 1'b1;
  logic [39:0] exp_q[$];

  always #5 clk = ~clk;

  rom_dl_sdram_packer dut (
    .i_EMU_MCLK(clk), .i_EMU_INITRST_n(rst_n),
    .ioctl_download(download), .ioctl_index(index), .ioctl_addr(addr),
    .ioctl_data(data), .ioctl_wr(wr), .ioctl_wait(wait_o),
    .o_SDRAM_WR_REQ(req), .o_SDRAM_WR_ADDR(wr_addr), .o_SDRAM_WR_DATA(wr_data),
    .o_SDRAM_WR_BE(wr_be), .i_SDRAM_WR_ACK(ack), .o_DL_BUSY(busy), .o_DL_DONE(done)
  );

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else
      $display("ok   %s: %h", name, act);
  endtask

  task automatic expect_word(input logic [21:0] a, input logic [15:0] d, input logic [1:0] b);
    exp_q.push_back({a, d, b});
  endtask

  // Responder + monitor: ack one cycle in two while enabled, compare each accepted write.
  initial begin
    bit prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_done) check("busy_after_done", {39'd0, busy}, 40'd0);
      prev_done = 1'b0;
      if (done) begin
        done_cnt++;
        check("busy_with_done", {39'd0, busy}, 40'd1);
        prev_done = 1'b1;
      end
      ack = (rst_n && ack_en && req && !ack);
      if (ack) begin
        if (exp_q.size() == 0)
          check("unexpected_write", {wr_addr, wr_data, wr_be}, 40'hFFFFFFFFFF);
        else
          check("sdram_write", {wr_addr, wr_data, wr_be}, exp_q.pop_front());
      end
    end
  end

  task automatic wr_byte(input logic [26:0] a, input logic [7:0] d);
    int t = 0;
    while (wait_o && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check("wait_timeout", 40'd1, 40'd0);
    addr = a; data = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_dl(input logic [15:0] idx);
    index = idx; download = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic end_dl_wait_done(input string name);
    int t = 0;
    int target = done_cnt + 1;
    download = 1'b0;
    while (done_cnt < target && t < 300) begin @(negedge clk); t++; end
    check(name, {39'd0, done_cnt >= target}, 40'd1);
    check({name, "_queue_empty"}, 40'(exp_q.size()), 40'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1;
    check("reset_outputs", {33'd0, req, wait_o, busy, done, wr_be[0], wr_be[1], |wr_data}, 40'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: full word
    start_dl(16'd0);
    check("busy_in_load", {39'd0, busy}, 40'd1);
    expect_word(22'd0, 16'h2211, 2'b11);
    wr_byte(27'd0, 8'h11);
    wr_byte(27'd1, 8'h22);
    end_dl_wait_done("t1_done");

    // 2: flushed lone even byte
    start_dl(16'd0);
    expect_word(22'd0, 16'h00AA, 2'b01);
    wr_byte(27'd0, 8'hAA);
    end_dl_wait_done("t2_done");

    // 3: backpressure with ack held off
    ack_en = 1'b0;
    start_dl(16'd0);
    for (int k = 0; k < 8; k++)
      expect_word(22'(k), {8'(8'h31 + 2 * k), 8'(8'h30 + 2 * k)}, 2'b11);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) check("wait_at_count2", {39'd0, wait_o}, 40'd0);
      wr_byte(27'(i), 8'(8'h30 + i));
    end
    check("wait_at_count3", {39'd0, wait_o}, 40'd1);
    repeat (3) @(negedge clk);
    check("wait_held", {39'd0, wait_o}, 40'd1);
    ack_en = 1'b1;
    for (int i = 6; i < 16; i++) wr_byte(27'(i), 8'(8'h30 + i));
    end_dl_wait_done("t3_done");

    // 4: non-contiguous even bytes
    start_dl(16'd0);
    expect_word(22'd2, 16'h0001, 2'b01);
    expect_word(22'd4, 16'h0002, 2'b01);
    wr_byte(27'd4, 8'h01);
    wr_byte(27'd8, 8'h02);
    end_dl_wait_done("t4_done");

    // 5: foreign index ignored
    start_dl(16'd1);
    wr_byte(27'd0, 8'h55);
    wr_byte(27'd1, 8'h66);
    repeat (3) @(negedge clk);
    check("t5_idle", {37'd0, req, wait_o, busy}, 40'd0);
    download = 1'b0;
    index = 16'd0;
    repeat (3) @(negedge clk);
    check("t5_no_done", 40'(done_cnt), 40'd4);

    // 6: reset with 3 words queued
    ack_en = 1'b0;
    start_dl(16'd0);
    for (int i = 0; i < 6; i++) wr_byte(27'(i), 8'(8'h70 + i));
    check("t6_req_before_reset", {39'd0, req}, 40'd1);
    rst_n = 1'b0;
    download = 1'b0;
    #1;
    check("t6_reset_outputs", {36'd0, req, wait_o, busy, done}, 40'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ack_en = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_no_done", 40'(done_cnt), 40'd4);
    check("t6_no_req", {39'd0, req}, 40'd0);
    start_dl(16'd0);
    expect_word(22'd0, 16'h5544, 2'b11);
    wr_byte(27'd0, 8'h44);
    wr_byte(27'd1, 8'h55);
    end_dl_wait_done("t6_clean_done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
